// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder sampling blocks: count width,
// default period width and the homing state encoding.
package encoder_pkg;

    localparam int CNT_W        = 32;
    localparam int PERIOD_W_DEF = 24;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_SEEK = 1'b1
    } home_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a
// rising-edge detector producing a one-cycle pulse.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/encoder_sample_ctrl.sv
// Periodic sampler of the decoder position count (home-relative position
// and raw-count speed) plus an index-based homing state machine.
module encoder_sample_ctrl
    import encoder_pkg::*;
#(
    parameter int P_PERIOD_W     = PERIOD_W_DEF,
    parameter int P_HOME_TIMEOUT = 50_000_000
) (
    input  logic                  I_sys_clk,
    input  logic                  I_sys_rst,
    input  logic [CNT_W-1:0]      I_Decode_data,
    input  logic                  I_Encode_Z,
    input  logic [P_PERIOD_W-1:0] I_Period,
    input  logic                  I_Home_req,
    output logic [CNT_W-1:0]      O_Pos,
    output logic [CNT_W-1:0]      O_Speed,
    output logic                  O_Sample_valid,
    output logic                  O_Home_busy,
    output logic                  O_Home_done,
    output logic                  O_Home_err
);

    localparam int             TMO_W    = $clog2(P_HOME_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_HOME_TIMEOUT - 1);

    logic                  w_z_rise;
    logic [P_PERIOD_W-1:0] w_peff;
    logic                  w_wrap;

    logic [P_PERIOD_W-1:0] r_peff;
    logic [P_PERIOD_W-1:0] r_cnt;
    logic [CNT_W-1:0]      r_raw_prev;
    logic [CNT_W-1:0]      r_offset;
    logic [CNT_W-1:0]      r_pos;
    logic [CNT_W-1:0]      r_speed;
    logic                  r_valid;

    home_state_t           r_state;
    home_state_t           w_state_nxt;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_done;
    logic                  r_err;
    logic                  w_home_start;
    logic                  w_home_ok;
    logic                  w_home_tmo;

    sync_edge u_sync_z (
        .i_clk   (I_sys_clk),
        .i_rst   (I_sys_rst),
        .i_async (I_Encode_Z),
        .o_rise  (w_z_rise)
    );

    // Period is clamped to 2 and latched per window so a mid-window write
    // cannot shorten or stretch the window already in progress.
    assign w_peff = (I_Period < P_PERIOD_W'(2)) ? P_PERIOD_W'(2) : I_Period;
    assign w_wrap = (r_cnt == r_peff - P_PERIOD_W'(1));

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_peff     <= w_peff;
            r_cnt      <= '0;
            r_raw_prev <= '0;
            r_pos      <= '0;
            r_speed    <= '0;
            r_valid    <= 1'b0;
        end else if (w_wrap) begin
            r_peff     <= w_peff;
            r_cnt      <= '0;
            r_raw_prev <= I_Decode_data;
            r_speed    <= I_Decode_data - r_raw_prev;
            r_pos      <= I_Decode_data - r_offset;
            r_valid    <= 1'b1;
        end else begin
            r_cnt      <= r_cnt + P_PERIOD_W'(1);
            r_valid    <= 1'b0;
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) r_state <= H_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_home_start = 1'b0;
        w_home_ok    = 1'b0;
        w_home_tmo   = 1'b0;
        case (r_state)
            H_IDLE: begin
                if (I_Home_req) begin
                    w_home_start = 1'b1;
                    w_state_nxt  = H_SEEK;
                end
            end
            H_SEEK: begin
                if (w_z_rise) begin
                    w_home_ok   = 1'b1;
                    w_state_nxt = H_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_home_tmo  = 1'b1;
                    w_state_nxt = H_IDLE;
                end
            end
            default: w_state_nxt = H_IDLE;
        endcase
    end

    // The offset only moves on a successful index capture; the sampler reads
    // the registered value, so a same-cycle capture affects the next sample.
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_offset <= '0;
            r_tmo    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_home_start) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_tmo  <= '0;
            end else if (r_state == H_SEEK) begin
                r_tmo  <= r_tmo + TMO_W'(1);
            end
            if (w_home_ok) begin
                r_offset <= I_Decode_data;
                r_done   <= 1'b1;
            end
            if (w_home_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign O_Pos          = r_pos;
    assign O_Speed        = r_speed;
    assign O_Sample_valid = r_valid;
    assign O_Home_busy    = (r_state == H_SEEK);
    assign O_Home_done    = r_done;
    assign O_Home_err     = r_err;

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Directed self-checking bench for encoder_sample_ctrl.
module tb_encoder_sample_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        z;
    logic [23:0] period;
    logic        home_req;
    logic [31:0] pos;
    logic [31:0] speed;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_errors;

    encoder_sample_ctrl #(
        .P_PERIOD_W     (24),
        .P_HOME_TIMEOUT (1000)
    ) dut (
        .I_sys_clk      (clk),
        .I_sys_rst      (rst),
        .I_Decode_data  (data),
        .I_Encode_Z     (z),
        .I_Period       (period),
        .I_Home_req     (home_req),
        .O_Pos          (pos),
        .O_Speed        (speed),
        .O_Sample_valid (valid),
        .O_Home_busy    (busy),
        .O_Home_done    (done),
        .O_Home_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 500);
        if (!valid) chk(tag, 32'(valid), 32'd1);
    endtask

    task automatic pulse_home();
        home_req = 1'b1;
        tick();
        home_req = 1'b0;
    endtask

    task automatic chk_all_zero();
        chk("rst_pos",   pos,          32'd0);
        chk("rst_speed", speed,        32'd0);
        chk("rst_valid", 32'(valid),   32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_err",   32'(err),     32'd0);
    endtask

    initial begin
        int since;
        int nvalid;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        data     = 32'd0;
        z        = 1'b0;
        period   = 24'd100;
        home_req = 1'b0;

        ticks(3);
        chk_all_zero();
        rst = 1'b0;

        // Steady +1 per clock, period 100
        since  = 0;
        nvalid = 0;
        for (int n = 0; n < 600 && nvalid < 4; n++) begin
            tick();
            since++;
            if (valid) begin
                if (nvalid == 0) begin
                    chk("first_speed", speed, data);
                end else begin
                    chk("steady_interval", 32'(since), 32'd100);
                    chk("steady_speed", speed, 32'd100);
                end
                chk("steady_pos", pos, data);
                nvalid++;
                since = 0;
            end
            data = data + 32'd1;
        end
        chk("steady_nvalid", 32'(nvalid), 32'd4);

        // Raw counter wrap within one window
        wait_valid("wrap_a_timeout");
        data = 32'hFFFF_FFF0;
        wait_valid("wrap_b_timeout");
        data = 32'h0000_0010;
        wait_valid("wrap_c_timeout");
        chk("wrap_speed", speed, 32'h0000_0020);
        chk("wrap_pos",   pos,   32'h0000_0010);

        // Reverse motion, period 2 (takes effect from the next window)
        period = 24'd2;
        wait_valid("rev_sync_timeout");
        for (int k = 0; k < 4; k++) begin
            data  = data - 32'd5;
            since = 0;
            do begin
                tick();
                since++;
            end while (!valid && since < 10);
            chk("rev_interval", 32'(since), 32'd2);
            chk("rev_speed", speed, 32'hFFFF_FFFB);
        end

        // Period 0 clamps to 2
        period = 24'd0;
        wait_valid("p0_sync_timeout");
        since = 0;
        do begin
            tick();
            since++;
        end while (!valid && since < 10);
        chk("p0_interval", 32'(since), 32'd2);
        chk("p0_speed", speed, 32'd0);

        // Homing success at count 1234
        period = 24'd10;
        wait_valid("home_sync_a_timeout");
        wait_valid("home_sync_b_timeout");
        pulse_home();
        chk("home_busy_rise", 32'(busy), 32'd1);
        chk("home_done_low",  32'(done), 32'd0);
        data = 32'd1234;
        z    = 1'b1;
        ticks(2);
        chk("home_busy_mid", 32'(busy), 32'd1);
        tick();
        chk("home_done", 32'(done), 32'd1);
        chk("home_busy_fall", 32'(busy), 32'd0);
        z    = 1'b0;
        data = 32'd1300;
        wait_valid("home_s1_timeout");
        chk("home_pos66", pos, 32'd66);
        data = 32'd1400;
        wait_valid("home_s2_timeout");
        chk("home_pos166", pos, 32'd166);
        chk("home_speed", speed, 32'd100);

        // Index capture on the same cycle as a sample wrap
        data = 32'd5000;
        pulse_home();
        chk("sim_done_clr", 32'(done), 32'd0);
        wait_valid("sim_sync_timeout");
        ticks(7);
        z = 1'b1;
        ticks(3);
        chk("sim_valid", 32'(valid), 32'd1);
        chk("sim_done", 32'(done), 32'd1);
        chk("sim_old_offset", pos, 32'd3766);
        z    = 1'b0;
        data = 32'd5100;
        wait_valid("sim_next_timeout");
        chk("sim_new_offset", pos, 32'd100);

        // Homing timeout after exactly 1000 clocks in seek
        pulse_home();
        chk("tmo_busy", 32'(busy), 32'd1);
        ticks(999);
        chk("tmo_err_early", 32'(err), 32'd0);
        chk("tmo_busy_hold", 32'(busy), 32'd1);
        tick();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy_fall", 32'(busy), 32'd0);
        chk("tmo_done", 32'(done), 32'd0);
        data = 32'd6000;
        wait_valid("tmo_s_timeout");
        chk("tmo_offset_kept", pos, 32'd1000);

        // Reset during seek, then an index edge must be ignored
        pulse_home();
        chk("rs_err_clr", 32'(err), 32'd0);
        ticks(5);
        rst = 1'b1;
        tick();
        chk_all_zero();
        rst = 1'b0;
        z   = 1'b1;
        ticks(5);
        chk("rs_z_done", 32'(done), 32'd0);
        chk("rs_z_busy", 32'(busy), 32'd0);
        data = 32'd777;
        wait_valid("rs_s_timeout");
        chk("rs_offset_zero", pos, 32'd777);
        chk("rs_first_speed", speed, 32'd777);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/encoder_sample_ctrl.md
# encoder_sample_ctrl

Sequencing controller for the quadrature `decode` datapath. It samples the decoder's 32-bit position count on a programmable period and produces a home-relative position and a per-window speed (delta count). It also runs a homing state machine that zeroes position on the Z index edge after a home request. It sits between `decode` and the motor control loop, which consumes `O_Sample_valid`-qualified data.

## Interface
- `P_PERIOD_W`, 24: width of the sample-period input.
- `P_HOME_TIMEOUT`, 50_000_000: clocks allowed for the index search before an error is raised.
- `I_sys_clk`  in  1  system clock; the single clock domain.
- `I_sys_rst`  in  1  synchronous, active-high reset.
- `I_Decode_data`  in  32  raw position count from `decode`.
- `I_Encode_Z`  in  1  raw encoder index, asynchronous to the clock.
- `I_Period`  in  P_PERIOD_W  sample period in clocks; values below 2 are treated as 2.
- `I_Home_req`  in  1  single-cycle pulse that starts homing.
- `O_Pos`  out  32  `I_Decode_data - offset`, latched at each sample.
- `O_Speed`  out  32  signed count delta over the last window.
- `O_Sample_valid`  out  1  one-cycle pulse; `O_Pos` and `O_Speed` are updated in the same cycle.
- `O_Home_busy`  out  1  high while in `H_SEEK`.
- `O_Home_done`  out  1  level; set on successful homing, cleared by a new request.
- `O_Home_err`  out  1  level; set on timeout, cleared by a new request.

## Operation
- **Index synchroniser:** 2-flop synchroniser on `I_Encode_Z`, followed by rising-edge detect. This yields `z_rise`, a one-cycle pulse.
- **Sample timer:** `cnt` counts 0..Peff-1, where Peff = max(`I_Period`, 2).
  - At `cnt` == Peff-1: `raw_prev` <= `I_Decode_data`, `O_Speed` <= `I_Decode_data - raw_prev`, `O_Pos` <= `I_Decode_data - offset`, `cnt` <= 0, `O_Sample_valid` <= 1.
  - `I_Period` is sampled at each wrap. A mid-window change takes effect in the next window.
- **Arithmetic:** all subtraction is modulo 2^32. Speed is interpreted as two's complement, so the raw counter wrapping 0xFFFFFFFF -> 0 gives a correct small delta.
- **Speed source:** speed is computed from raw counts, so a homing event never disturbs `O_Speed`.
- **Homing FSM:**
  - `H_IDLE`: on `I_Home_req`, clear `O_Home_done` and `O_Home_err`, clear the timeout counter, go to `H_SEEK`.
  - `H_SEEK`:
    - On `z_rise`: `offset` <= `I_Decode_data`, set `O_Home_done`, go to `H_IDLE`.
    - Else on timeout counter == P_HOME_TIMEOUT-1: set `O_Home_err`, go to `H_IDLE` with `offset` unchanged.
    - `I_Home_req` is ignored in this state.
  - `z_rise` in `H_IDLE` has no effect.
- **Simultaneous events:**
  - `z_rise` and sample wrap in the same cycle: the sample uses the OLD `offset`; the new `offset` applies from the next sample.
  - `I_Home_req` and sample wrap in the same cycle: both are processed independently.

## Timing
- **Reset:** all outputs 0. `cnt`, `raw_prev`, `offset`, timeout counter and synchroniser flops are 0. FSM is in `H_IDLE`.
- **First sample after reset:** `O_Speed` equals `I_Decode_data - 0`. The consumer discards the first valid.
- **Reset mid-homing:** reset returns the FSM to `H_IDLE` with `O_Home_done`/`O_Home_err` low and `offset` at 0.
- **Sample rate:** `O_Sample_valid` asserts in the cycle after the wrap compare, once every Peff clocks.
- **Data latency:** 1 clock from the data sampled in the compare cycle.
- **Index latency:** the `I_Encode_Z` rising edge is captured into `offset` 3 clocks after the edge (2 sync + 1 register). `I_Decode_data` at that cycle is used.
- **Homing status:** `O_Home_busy` rises 1 clock after `I_Home_req`. It falls in the same cycle that `O_Home_done` or `O_Home_err` rises.

## Structure
- **Shared package `encoder_pkg`:** FSM state encoding (`H_IDLE`, `H_SEEK`), the 32-bit count width constant, and the `P_PERIOD_W` default.
- **Sub-module `sync_edge`:** 2-flop synchroniser plus rising-edge detector. Reused later for the A/B inputs.
- Everything else is flat.

## Test plan
- **Steady count:** `I_Period`=100 and `I_Decode_data` incrementing +1 per clock -> after the first valid, `O_Speed`=100 on every valid, with valids 100 clocks apart.
- **Counter wrap:** `I_Decode_data` steps from 0xFFFFFFF0 to 0x00000010 within one window -> `O_Speed`=0x00000020.
- **Reverse motion:** count decreasing by 5 per window with `I_Period`=2 -> `O_Speed`=0xFFFFFFFB every 2 clocks.
- **Homing success:** `I_Home_req` pulse, then Z rising edge while `I_Decode_data`=1234 -> `O_Home_done`=1, `O_Home_busy`=0. Next sample with `I_Decode_data`=1300 gives `O_Pos`=66, and `O_Speed` is undisturbed.
- **Homing timeout:** P_HOME_TIMEOUT=1000, `I_Home_req` with no Z edge -> `O_Home_err`=1 exactly 1000 clocks after entering `H_SEEK`, and `offset` unchanged.
- **Boundary cases:** `I_Period`=0 behaves as 2. Assert `I_sys_rst` during `H_SEEK` -> all outputs 0 next clock, then a Z edge is ignored. Drive `z_rise` on the same cycle as a wrap -> that sample uses the old offset.
